bnn_layer_sequencer: RTL and testbench

- Time-multiplexes one XNOR-popcount-sign datapath across NUM_NEURONS binary neurons of a fully connected BNN layer.
- Holds a local weight store, written by the host through a simple write port.
- Accepts one input activation vector as a byte stream and evaluates each neuron one 8-bit word per cycle.
- Returns all neuron output bits together on a valid/ready result port; sits between the input byte stream and the next layer.

---
 rtl/bnn_layer_sequencer_if.sv | 31 +++
 rtl/bnn_layer_sequencer.sv | 144 ++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_layer_sequencer_if.sv
// Handshake and weight-write bundle of the BNN layer sequencer.
// The master is the producer/host side; the slave is the sequencer itself.
interface bnn_layer_sequencer_if #(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_WORDS   = 4
);
    localparam int NUM_ENTRIES = NUM_NEURONS * NUM_WORDS;
    localparam int ADDR_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [7:0]             wr_data;
    logic                   wr_err;
    logic [NUM_NEURONS-1:0] out_bits;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport master (
        output in_data, in_valid, wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, wr_err, out_bits, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, wr_en, wr_addr, wr_data, out_ready,
        output in_ready, wr_err, out_bits, out_valid, busy
    );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Time-multiplexed XNOR-popcount-sign evaluator for one fully connected BNN layer.
// Buffers one activation vector, then walks every neuron one byte per cycle.
module bnn_layer_sequencer #(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_WORDS   = 4,
    parameter int THRESH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bnn_layer_sequencer_if.slave io
);
    localparam int NUM_ENTRIES = NUM_NEURONS * NUM_WORDS;
    localparam int ADDR_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int ADDR_W1     = ADDR_W + 1;
    localparam int ACC_W       = $clog2(8 * NUM_WORDS + 1);
    localparam int WCNT_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int NCNT_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [31:0] THRESH_U = 32'(THRESH);

    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUTPUT} state_t;

    state_t                 state_q;
    logic [WCNT_W-1:0]      word_cnt_q;
    logic [NCNT_W-1:0]      neuron_cnt_q;
    logic [ACC_W-1:0]       acc_q;
    logic [7:0]             act_q    [NUM_WORDS];
    logic [7:0]             weight_q [NUM_ENTRIES];
    logic [NUM_NEURONS-1:0] out_bits_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   out_valid_q;
    logic                   wr_err_q;

    logic                   last_word_d;
    logic                   last_neuron_d;
    logic                   wr_in_range_d;
    logic                   wr_ok_d;
    logic                   fire_d;
    logic [ADDR_W-1:0]      rd_idx_d;
    logic [7:0]             match_d;
    logic [ACC_W-1:0]       sum_d;

    always_comb begin
        last_word_d   = (word_cnt_q == WCNT_W'(NUM_WORDS - 1));
        last_neuron_d = (neuron_cnt_q == NCNT_W'(NUM_NEURONS - 1));
        wr_in_range_d = ({1'b0, io.wr_addr} < ADDR_W1'(NUM_ENTRIES));
        // Weights are frozen while a vector is being evaluated.
        wr_ok_d       = io.wr_en && wr_in_range_d && (state_q != ST_COMPUTE);
        rd_idx_d      = ADDR_W'(neuron_cnt_q) * ADDR_W'(NUM_WORDS) + ADDR_W'(word_cnt_q);
        match_d       = ~(act_q[word_cnt_q] ^ weight_q[rd_idx_d]);
        sum_d         = acc_q;
        for (int b = 0; b < 8; b++) begin
            sum_d = sum_d + ACC_W'(match_d[b]);
        end
        fire_d        = (32'(sum_d) >= THRESH_U);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                weight_q[i] <= 8'h00;
            end
        end else if (wr_ok_d) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (io.wr_addr == ADDR_W'(i)) begin
                    weight_q[i] <= io.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= ST_LOAD;
            word_cnt_q   <= '0;
            neuron_cnt_q <= '0;
            acc_q        <= '0;
            out_bits_q   <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            wr_err_q     <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                act_q[i] <= 8'h00;
            end
        end else begin
            wr_err_q <= io.wr_en && !wr_ok_d;
            case (state_q)
                ST_LOAD: begin
                    if (io.in_valid) begin
                        act_q[word_cnt_q] <= io.in_data;
                        if (last_word_d) begin
                            word_cnt_q   <= '0;
                            neuron_cnt_q <= '0;
                            acc_q        <= '0;
                            state_q      <= ST_COMPUTE;
                            in_ready_q   <= 1'b0;
                            busy_q       <= 1'b1;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (last_word_d) begin
                        out_bits_q[neuron_cnt_q] <= fire_d;
                        acc_q      <= '0;
                        word_cnt_q <= '0;
                        if (last_neuron_d) begin
                            neuron_cnt_q <= '0;
                            state_q      <= ST_OUTPUT;
                            busy_q       <= 1'b0;
                            out_valid_q  <= 1'b1;
                        end else begin
                            neuron_cnt_q <= neuron_cnt_q + 1'b1;
                        end
                    end else begin
                        acc_q      <= sum_d;
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    // in_valid is deliberately ignored here, even on the release edge.
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                default: begin
                    state_q    <= ST_LOAD;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.busy      = busy_q;
    assign io.out_valid = out_valid_q;
    assign io.out_bits  = out_bits_q;
    assign io.wr_err    = wr_err_q;
endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench: a vector-level reference model is compared every cycle,
// with directed vectors pinned to hand-computed results and a random soak.
`timescale 1ns/1ps
module tb_bnn_layer_sequencer;
    localparam int NN = 4;
    localparam int NWD = 4;
    localparam int TH = 16;
    localparam int NE = NN * NWD;
    localparam int PH_LOAD = 0;
    localparam int PH_COMPUTE = 1;
    localparam int PH_OUTPUT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bnn_layer_sequencer_if #(.NUM_NEURONS(NN), .NUM_WORDS(NWD)) io ();
    bnn_layer_sequencer #(.NUM_NEURONS(NN), .NUM_WORDS(NWD), .THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .io(io)
    );

    // Second instance with a non-power-of-two weight store to reach out-of-range addresses.
    bnn_layer_sequencer_if #(.NUM_NEURONS(3), .NUM_WORDS(4)) io2 ();
    bnn_layer_sequencer #(.NUM_NEURONS(3), .NUM_WORDS(4), .THRESH(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .io(io2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_phase;
    int               m_wc;
    int               m_cd;
    logic [NN-1:0]    m_bits;
    logic             m_wr_err;
    logic [7:0]       m_w   [NE];
    logic [7:0]       m_act [NWD];

    function automatic logic [NN-1:0] eval_layer();
        logic [8*NWD-1:0] a;
        logic [8*NWD-1:0] w;
        logic [NN-1:0]    r;
        for (int k = 0; k < NWD; k++) a[8*k +: 8] = m_act[k];
        for (int n = 0; n < NN; n++) begin
            for (int k = 0; k < NWD; k++) w[8*k +: 8] = m_w[n*NWD + k];
            r[n] = ($countones(~(a ^ w)) >= TH);
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_phase  <= PH_LOAD;
            m_wc     <= 0;
            m_cd     <= 0;
            m_bits   <= '0;
            m_wr_err <= 1'b0;
            for (int i = 0; i < NE; i++) m_w[i] <= 8'h00;
        end else begin
            m_wr_err <= io.wr_en && (m_phase == PH_COMPUTE || int'(io.wr_addr) >= NE);
            if (io.wr_en && m_phase != PH_COMPUTE && int'(io.wr_addr) < NE)
                m_w[io.wr_addr] <= io.wr_data;
            case (m_phase)
                PH_LOAD: if (io.in_valid) begin
                    m_act[m_wc] <= io.in_data;
                    if (m_wc == NWD - 1) begin
                        m_wc    <= 0;
                        m_cd    <= NE;
                        m_phase <= PH_COMPUTE;
                    end else begin
                        m_wc <= m_wc + 1;
                    end
                end
                PH_COMPUTE: begin
                    if (m_cd == 1) begin
                        m_phase <= PH_OUTPUT;
                        m_bits  <= eval_layer();
                    end
                    m_cd <= m_cd - 1;
                end
                default: if (io.out_ready) m_phase <= PH_LOAD;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("in_ready", io.in_ready, m_phase == PH_LOAD);
            chk("busy", io.busy, m_phase == PH_COMPUTE);
            chk("out_valid", io.out_valid, m_phase == PH_OUTPUT);
            chk("wr_err", io.wr_err, m_wr_err);
            if (m_phase != PH_COMPUTE) chk("out_bits", io.out_bits, m_bits);
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_w(input int addr, input logic [7:0] data, output logic err);
        io.wr_en = 1'b1;
        io.wr_addr = addr[3:0];
        io.wr_data = data;
        step();
        io.wr_en = 1'b0;
        err = io.wr_err;
        $display("write addr=%0d data=%02h wr_err=%0b", addr, data, err);
    endtask

    task automatic set_neuron(input int n, input logic [7:0] w0, w1, w2, w3);
        logic e;
        write_w(n*NWD + 0, w0, e);
        write_w(n*NWD + 1, w1, e);
        write_w(n*NWD + 2, w2, e);
        write_w(n*NWD + 3, w3, e);
    endtask

    task automatic send_vec(input logic [7:0] v0, v1, v2, v3);
        logic [7:0] v [4];
        logic rdy;
        int guard;
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            io.in_valid = 1'b1;
            io.in_data = v[i];
            guard = 0;
            do begin
                rdy = io.in_ready;
                step();
                guard++;
            end while (!rdy && guard < 100);
            chk("accept_timeout", rdy, 1);
        end
        io.in_valid = 1'b0;
        $display("vector %02h %02h %02h %02h accepted", v0, v1, v2, v3);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("out_valid_timeout", io.out_valid, 1);
    endtask

    task automatic take_result(input string name, input logic [NN-1:0] exp);
        int lat;
        wait_valid(lat);
        chk(name, io.out_bits, exp);
        chk({name, "_model"}, m_bits, exp);
        $display("result %s out_bits=%04b", name, io.out_bits);
        io.out_ready = 1'b1;
        step();
        io.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int lat;
        io.in_valid = 0; io.in_data = 0; io.wr_en = 0; io.wr_addr = 0; io.wr_data = 0; io.out_ready = 0;
        io2.in_valid = 0; io2.in_data = 0; io2.wr_en = 0; io2.wr_addr = 0; io2.wr_data = 0; io2.out_ready = 0;

        repeat (2) step();
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_busy", io.busy, 0);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_out_bits", io.out_bits, 0);
        chk("rst_wr_err", io.wr_err, 0);
        rst_n = 1'b0;
        step();

        // Zero weights, zero inputs: every bit matches, 32 >= 16.
        send_vec(8'h00, 8'h00, 8'h00, 8'h00);
        wait_valid(lat);
        chk("latency", lat, NE);
        take_result("zero_vec", 4'b1111);

        // All 0xFF weights and inputs.
        for (int n = 0; n < NN; n++) set_neuron(n, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        send_vec(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_valid(lat);
        chk("latency_ff", lat, NE);
        take_result("all_ff", 4'b1111);

        // Threshold boundary: 16, 15, 16, 16 matches.
        set_neuron(1, 8'hFF, 8'hFE, 8'hFF, 8'hFF);
        set_neuron(2, 8'h00, 8'h00, 8'h00, 8'h00);
        set_neuron(3, 8'h00, 8'h00, 8'h00, 8'h00);
        send_vec(8'hFF, 8'hFF, 8'h00, 8'h00);
        take_result("thresh", 4'b1101);

        // Backpressure with in_valid held on a foreign word.
        send_vec(8'hFF, 8'hFF, 8'h00, 8'h00);
        wait_valid(lat);
        io.in_valid = 1'b1;
        io.in_data = 8'hAA;
        repeat (5) begin
            step();
            chk("bp_in_ready", io.in_ready, 0);
            chk("bp_out_bits", io.out_bits, 4'b1101);
        end
        io.out_ready = 1'b1;
        step();
        chk("bp_release", io.out_valid, 0);
        io.out_ready = 1'b0;
        io.in_valid = 1'b0;
        send_vec(8'hFF, 8'hFF, 8'h00, 8'h00);
        take_result("bp_next", 4'b1101);

        // Write during COMPUTE is rejected and does not alter results.
        send_vec(8'hFF, 8'hFF, 8'h00, 8'h00);
        repeat (3) step();
        write_w(0, 8'h00, e);
        chk("compute_wr_err", e, 1);
        step();
        chk("compute_wr_err_pulse", io.wr_err, 0);
        take_result("compute_wr_old", 4'b1101);
        write_w(0, 8'h00, e);
        chk("load_wr_err", e, 0);
        send_vec(8'hFF, 8'hFF, 8'h00, 8'h00);
        take_result("load_wr_new", 4'b1100);

        // Out-of-range address on a 12-entry store.
        io2.wr_en = 1'b1; io2.wr_addr = 4'd13; io2.wr_data = 8'h5A;
        step();
        io2.wr_en = 1'b0;
        chk("oor_wr_err", io2.wr_err, 1);
        io2.wr_en = 1'b1; io2.wr_addr = 4'd5;
        step();
        io2.wr_en = 1'b0;
        chk("inrange_wr_err", io2.wr_err, 0);

        // Reset in the 7th COMPUTE cycle.
        send_vec(8'hFF, 8'hFF, 8'h00, 8'h00);
        repeat (6) step();
        #1 rst_n = 1'b1;
        #1;
        chk("midrst_busy", io.busy, 0);
        chk("midrst_out_valid", io.out_valid, 0);
        chk("midrst_in_ready", io.in_ready, 1);
        chk("midrst_out_bits", io.out_bits, 0);
        step();
        rst_n = 1'b0;
        step();
        send_vec(8'hFF, 8'hFF, 8'h00, 8'h00);
        take_result("after_rst", 4'b1111);

        // Random soak against the model.
        for (int c = 0; c < 1500; c++) begin
            io.in_valid = 1'($urandom_range(0, 1));
            io.in_data = 8'($urandom);
            io.wr_en = ($urandom_range(0, 9) == 0);
            io.wr_addr = 4'($urandom_range(0, NE - 1));
            io.wr_data = 8'($urandom);
            io.out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (io.out_valid && io.out_ready)
                $display("random cycle %0d out_bits=%04b", c, io.out_bits);
        end
        io.in_valid = 0; io.wr_en = 0; io.out_ready = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
